// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 status/cause/EPC block: decides exception or interrupt entry in the
// commit cycle, records the victim context, and serves mfc0/mtc0 and eret.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID       = 32'h0000_2019,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hw_int,
  input  logic [4:0]  sel,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  input  logic        bd,
  input  logic [4:0]  exc_code,
  input  logic        eret,
  output logic [31:0] rdata,
  output logic        req,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc
);

  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd_q;
  logic [5:0]  ip;
  logic [4:0]  exc_q;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        write_sr;
  logic        write_epc;
  logic [31:0] epc_victim;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign int_req = (|(hw_int & im)) & ie & ~exl;
  assign exc_req = (exc_code != 5'd0) & ~exl;
  assign req     = int_req | exc_req;

  // An exception taken in the same cycle discards any pending mtc0.
  assign write_sr  = we & ~req & (sel == SEL_SR);
  assign write_epc = we & ~req & (sel == SEL_EPC);

  // Delay-slot victims resume at the branch; EPC is always word aligned.
  assign epc_victim = (bd ? (pc - 32'd4) : pc) & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (reset) begin
      im    <= 6'd0;
      exl   <= 1'b0;
      ie    <= 1'b0;
      bd_q  <= 1'b0;
      ip    <= 6'd0;
      exc_q <= 5'd0;
      epc   <= 32'd0;
    end else begin
      ip <= hw_int;
      if (req) begin
        exl   <= 1'b1;
        exc_q <= int_req ? 5'd0 : exc_code;
        bd_q  <= bd;
        epc   <= epc_victim;
      end else begin
        if (write_sr) begin
          im  <= wdata[15:10];
          exl <= wdata[1];
          ie  <= wdata[0];
        end
        if (write_epc) begin
          epc <= wdata;
        end
        if (eret) begin
          exl <= 1'b0;
        end
      end
    end
  end

  assign sr_word    = {16'd0, im, 8'd0, exl, ie};
  assign cause_word = {bd_q, 15'd0, ip, 3'd0, exc_q, 2'd0};

  always_comb begin
    rdata = 32'd0;
    case (sel)
      SEL_SR:    rdata = sr_word;
      SEL_CAUSE: rdata = cause_word;
      SEL_EPC:   rdata = epc;
      SEL_PRID:  rdata = PRID;
      default:   rdata = 32'd0;
    endcase
  end

  // Lets an eret pick up an EPC being written by mtc0 in the same cycle.
  assign epc_out    = (we && (sel == SEL_EPC)) ? wdata : epc;
  assign handler_pc = HANDLER_PC;

endmodule
